// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with a frame-synchronous double-buffered display value.
// Define SSD_LZB_EN to blank leading zero digits (digit 0 is always shown).
module ssd_scan_ctrl #(
    parameter int DIGIT_CYCLES = 262144,
    parameter int BLANK_CYCLES = 1024,
    parameter int NUM_DIGITS   = 8
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    output logic        load_ack,
    output logic        frame_start,
    output logic [7:0]  An,
    output logic [7:0]  Cathodes
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       d, d_nxt;
    logic             started;
    logic             boundary;
    logic [31:0]      disp_val, pend_val;
    logic [7:0]       disp_dp, pend_dp;
    logic             pend_flag;
    logic [7:0]       an_nxt, cath_nxt;

    // Active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

`ifdef SSD_LZB_EN
    // A digit is a leading zero when it and every higher scanned nibble are zero.
    function automatic logic lz_blank(input logic [31:0] v, input logic [2:0] idx);
        logic blank;
        blank = (idx != 3'd0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && v[4*i +: 4] != 4'h0) blank = 1'b0;
        end
        return blank;
    endfunction
`endif

    // The first edge after reset restarts the frame so frame_start pulses immediately.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        d_nxt     = d;
        boundary  = 1'b0;
        if (!started) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            d_nxt     = '0;
            boundary  = 1'b1;
        end else if (state == BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_nxt = SHOW;
                cnt_nxt   = '0;
            end
        end else if (cnt == DIGIT_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (d == LAST_DIGIT) begin
                d_nxt    = '0;
                boundary = 1'b1;
            end else begin
                d_nxt = d + 3'd1;
            end
        end

        an_nxt   = 8'hFF;
        cath_nxt = 8'hFF;
        if (state_nxt == SHOW) begin
            an_nxt[d_nxt] = 1'b0;
            cath_nxt      = {hex_to_seg(disp_val[4*d_nxt +: 4]), ~disp_dp[d_nxt]};
`ifdef SSD_LZB_EN
            if (lz_blank(disp_val, d_nxt)) cath_nxt[7:1] = 7'h7F;
`endif
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state   <= BLANK;
            cnt     <= '0;
            d       <= '0;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            d       <= d_nxt;
            started <= 1'b1;
        end
    end

    // Outputs and buffers; a load on the boundary edge lands in pending after the transfer.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            An          <= 8'hFF;
            Cathodes    <= 8'hFF;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
            disp_val    <= '0;
            disp_dp     <= '0;
            pend_val    <= '0;
            pend_dp     <= '0;
            pend_flag   <= 1'b0;
        end else begin
            An          <= an_nxt;
            Cathodes    <= cath_nxt;
            frame_start <= boundary;
            load_ack    <= boundary && pend_flag;
            if (boundary && pend_flag) begin
                disp_val  <= pend_val;
                disp_dp   <= pend_dp;
                pend_flag <= 1'b0;
            end
            if (load) begin
                pend_val  <= value;
                pend_dp   <= dp_mask;
                pend_flag <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DIGIT_CYCLES, 262144: ClkPort cycles a digit is lit (legal range 2..2^24).
- BLANK_CYCLES, 1024: all-off cycles between digits (legal range 1..2^16).
- NUM_DIGITS, 8: digits scanned (legal range 1..8).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- ClkPort, in, 1: single system clock (100 MHz).
- Reset, in, 1: reset, asynchronous, active-high.
- load, in, 1: one-cycle request to stage a new display value.
- value, in, 32: eight hex digits; digit i = value[4i+3:4i].
- dp_mask, in, 8: decimal point per digit, 1 = lit.
- load_ack, out, 1: one-cycle pulse when the staged value becomes displayed.
- frame_start, out, 1: one-cycle pulse at start of each scan frame.
- An, out, 8: anodes, active-low; An[i] drives digit i.
- Cathodes, out, 8: {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.

REQ-003 Clock SHALL be ClkPort only; reset SHALL be Reset only, asynchronous and active-high.

Function
REQ-004 The FSM SHALL have two states:
- BLANK: An = 8'hFF, Cathodes = 8'hFF, held for BLANK_CYCLES cycles.
- SHOW: An has bit d low, all others high; held for DIGIT_CYCLES cycles.

REQ-005 Transitions: BLANK->SHOW (same d) after BLANK_CYCLES; SHOW->BLANK with d <= d+1 after DIGIT_CYCLES.

REQ-006 d SHALL wrap from NUM_DIGITS-1 to 0; An bits >= NUM_DIGITS SHALL stay 1 in every state.

REQ-007 The dwell counter SHALL count 0..N-1 and clear on every state change; no cycle is added or dropped at transitions.

REQ-008 In SHOW, Cathodes SHALL be the hex-to-7-segment pattern of displayed digit d (0-F, standard a-g glyphs, segment on = 0), with Dp = ~shown_dp[d].

REQ-009 An and Cathodes SHALL be registered outputs: they change on the clock edge that enters the new state, with no glitch and no cycle where two anodes are low.

REQ-010 frame_start SHALL pulse high for exactly the first cycle of BLANK with d = 0.

REQ-011 Double buffer:
- load = 1 copies value and dp_mask into a pending register and sets a pending flag.
- At the frame boundary (edge entering BLANK with d = 0), if the pending flag is set, the displayed register <= pending, the flag clears, and load_ack pulses in that same first cycle.

REQ-012 Multiple loads within one frame: the last one wins, and only one load_ack is issued.

REQ-013 A load on the boundary edge itself SHALL be captured into pending and applied at the next frame. The transfer uses the pending contents held before that edge, and the flag stays set.

REQ-014 With NUM_DIGITS = 1, every SHOW->BLANK transition SHALL be a frame boundary.

Reset
REQ-015 While Reset is high, these SHALL hold asynchronously:
- state = BLANK, d = 0, counter = 0.
- An = 8'hFF, Cathodes = 8'hFF.
- load_ack = 0, frame_start = 0.
- displayed and pending registers = 0, pending flag = 0.

REQ-016 On the first edge after Reset deasserts, frame_start SHALL pulse; a frame in progress is abandoned by reset, and any pending value is lost.

Configuration
REQ-017 Macro SSD_LZB_EN SHALL control leading-zero blanking.
- Defined: in SHOW, a digit d > 0 whose displayed nibble is 0 and whose higher-index nibbles below NUM_DIGITS are all 0 SHALL drive Cathodes[7:1] = 7'h7F. Dp still follows dp_mask. Digit 0 is always shown.
- Undefined: all digits are shown unconditionally, and no blanking logic is present.

Verification
All scenarios use DIGIT_CYCLES = 8, BLANK_CYCLES = 2, NUM_DIGITS = 4 unless stated.

REQ-018 Reset released -> frame_start at cycle 1; An = FF for 2 cycles, then An = FE for 8 cycles, then FF for 2, then FD. Frame period = 40 cycles; An[7:4] always 1.

REQ-019 load value = 32'h0000_12AF, dp_mask = 8'h01 mid-frame -> load_ack pulses at the next frame_start only. Digit 0 Cathodes = 8'h70 (F with Dp lit, 0111_0000); digit 1 shows A (8'h11).

REQ-020 Three loads in one frame (values 1, 2, 3) -> one load_ack, display shows 3; no load_ack on the following frame.

REQ-021 load asserted on the boundary cycle with a prior pending 5 -> this frame shows 5, the next frame shows the new value, and load_ack pulses at both boundaries.

REQ-022 Reset asserted mid-SHOW -> An = FF and Cathodes = FF in the same cycle (asynchronous); pending is discarded and the display shows 0 after release.

REQ-023 SSD_LZB_EN defined, value = 32'h0000_0050 -> digits 3 and 2 fully blank, digit 1 shows 5, digit 0 shows 0. Undefined -> digits 3 and 2 show 0.
